// File: rtl/d_debounce.sv
// Synchronises an asynchronous raw input and debounces it with a consecutive-sample
// counter. Outputs a clean registered level plus one-cycle rise/fall pulses.
module d_debounce #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = 16,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic d_raw,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam state_t           RESET_STATE = RESET_VAL ? STABLE_HI : STABLE_LO;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;

  state_t           state_r;
  state_t           state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx_s;
  logic             q_r;
  logic             q_nx_s;
  logic             rise_r;
  logic             rise_nx_s;
  logic             fall_r;
  logic             fall_nx_s;
  logic             busy_r;
  logic             busy_nx_s;

  // Synchroniser chain: runs every cycle, independent of ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d_raw};
    end
  end

  assign s_s = sync_r[SYNC_STAGES-1];

  // Next-state, counter and pulse decode; only ce=1 samples advance the qualifier.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    q_nx_s     = q_r;
    rise_nx_s  = 1'b0;
    fall_nx_s  = 1'b0;
    if (ce) begin
      case (state_r)
        STABLE_LO: begin
          if (s_s) begin
            state_nx_s = WAIT_HI;
            cnt_nx_s   = CNT_ONE;
          end else begin
            state_nx_s = STABLE_LO;
            cnt_nx_s   = CNT_ZERO;
          end
        end
        WAIT_HI: begin
          if (!s_s) begin
            state_nx_s = STABLE_LO;
            cnt_nx_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_nx_s = STABLE_HI;
            cnt_nx_s   = CNT_ZERO;
            q_nx_s     = 1'b1;
            rise_nx_s  = 1'b1;
          end else begin
            state_nx_s = WAIT_HI;
            cnt_nx_s   = cnt_r + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s_s) begin
            state_nx_s = WAIT_LO;
            cnt_nx_s   = CNT_ONE;
          end else begin
            state_nx_s = STABLE_HI;
            cnt_nx_s   = CNT_ZERO;
          end
        end
        WAIT_LO: begin
          if (s_s) begin
            state_nx_s = STABLE_HI;
            cnt_nx_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_nx_s = STABLE_LO;
            cnt_nx_s   = CNT_ZERO;
            q_nx_s     = 1'b0;
            fall_nx_s  = 1'b1;
          end else begin
            state_nx_s = WAIT_LO;
            cnt_nx_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          // Unreachable encoding: fall back to the stable state matching q.
          state_nx_s = q_r ? STABLE_HI : STABLE_LO;
          cnt_nx_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
    end
    busy_nx_s = (state_nx_s == WAIT_HI) || (state_nx_s == WAIT_LO);
  end

  // Registered FSM state, counter and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RESET_STATE;
      cnt_r   <= CNT_ZERO;
      q_r     <= RESET_VAL;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      q_r     <= q_nx_s;
      rise_r  <= rise_nx_s;
      fall_r  <= fall_nx_s;
      busy_r  <= busy_nx_s;
    end
  end

  assign q    = q_r;
  assign rise = rise_r;
  assign fall = fall_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_d_debounce.sv
// Scoreboard bench for d_debounce: a run-length reference model queues the expected
// outputs per edge; directed checks confirm latency, pulse width and busy window.
module tb_d_debounce;

  localparam int SYNC = 2;
  localparam int STAB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic d_raw = 1'b0;
  logic q, rise, fall, busy;

  always #5 clk = ~clk;

  d_debounce #(
    .SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .CNT_W(16), .RESET_VAL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .d_raw(d_raw),
    .q(q), .rise(rise), .fall(fall), .busy(busy)
  );

  typedef struct packed {
    logic        q;
    logic        rise;
    logic        fall;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model: synchroniser image, debounced level, run length of disagreement
  logic [SYNC-1:0] m_sync = '0;
  logic m_q = 1'b0;
  int m_run = 0;

  // per-run observations
  int edge_no, rise_edge, fall_edge, rise_cnt, fall_cnt, busy_first, busy_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic d);
    exp_t e;
    logic s;
    @(negedge clk);
    rst = r; ce = c; d_raw = d;
    s = m_sync[SYNC-1];
    e = '0;
    if (r) begin
      m_sync = '0; m_q = 1'b0; m_run = 0;
    end else begin
      if (c) begin
        if (s != m_q) begin
          m_run++;
          if (m_run == STAB) begin
            m_q = s; m_run = 0; e.rise = s; e.fall = ~s;
          end
        end else begin
          m_run = 0;
        end
      end
      m_sync = {m_sync[SYNC-2:0], d};
    end
    e.q = m_q; e.busy = (m_run != 0); e.cnt = 16'(m_run);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    edge_no++;
    e = exp_q.pop_front();
    check_eq($sformatf("q@%0d", edge_no), 32'(q), 32'(e.q));
    check_eq($sformatf("rise@%0d", edge_no), 32'(rise), 32'(e.rise));
    check_eq($sformatf("fall@%0d", edge_no), 32'(fall), 32'(e.fall));
    check_eq($sformatf("busy@%0d", edge_no), 32'(busy), 32'(e.busy));
    check_eq($sformatf("cnt@%0d", edge_no), 32'(dut.cnt_r), 32'(e.cnt));
    if (rise && rise_edge == 0) rise_edge = edge_no;
    if (fall && fall_edge == 0) fall_edge = edge_no;
    if (rise) rise_cnt++;
    if (fall) fall_cnt++;
    if (busy && busy_first == 0) busy_first = edge_no;
    if (busy) busy_last = edge_no;
  endtask

  task automatic clear_obs();
    edge_no = 0; rise_edge = 0; fall_edge = 0; rise_cnt = 0; fall_cnt = 0;
    busy_first = 0; busy_last = 0;
  endtask

  // n edges with d_raw held; toggle_ce=1 gives ce = 1,0,1,0,...
  task automatic run(input int n, input logic d, input logic toggle_ce);
    for (int i = 0; i < n; i++) begin
      step(1'b0, toggle_ce ? ((i % 2) == 0) : 1'b1, d);
    end
  endtask

  initial begin
    clear_obs();
    // 1: reset with d_raw=1, then release
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    clear_obs();
    run(12, 1'b1, 1'b0);
    check_eq("t1_rise_edge", 32'(rise_edge), 32'd6);
    check_eq("t1_rise_width", 32'(rise_cnt), 32'd1);

    // 4: 1->0 step from q=1, then a 3-cycle high glitch
    clear_obs();
    run(10, 1'b0, 1'b0);
    check_eq("t4_fall_edge", 32'(fall_edge), 32'd6);
    check_eq("t4_fall_width", 32'(fall_cnt), 32'd1);
    clear_obs();
    run(3, 1'b1, 1'b0);
    run(8, 1'b0, 1'b0);
    check_eq("t4_glitch_rise", 32'(rise_cnt), 32'd0);
    check_eq("t4_glitch_q", 32'(q), 32'd0);

    // 2: clean 0->1 step
    clear_obs();
    run(10, 1'b1, 1'b0);
    check_eq("t2_rise_edge", 32'(rise_edge), 32'd6);
    check_eq("t2_busy_first", 32'(busy_first), 32'd3);
    check_eq("t2_busy_last", 32'(busy_last), 32'd5);
    check_eq("t2_rise_width", 32'(rise_cnt), 32'd1);
    check_eq("t2_no_fall", 32'(fall_cnt), 32'd0);
    run(10, 1'b0, 1'b0);

    // 3: 3-cycle high pulse from q=0
    clear_obs();
    run(3, 1'b1, 1'b0);
    run(8, 1'b0, 1'b0);
    check_eq("t3_rise", 32'(rise_cnt), 32'd0);
    check_eq("t3_fall", 32'(fall_cnt), 32'd0);
    check_eq("t3_busy_end", 32'(busy), 32'd0);
    check_eq("t3_q", 32'(q), 32'd0);

    // 5: ce toggling with d_raw high; ce=1 samples of s=1 at edges 3,5,7,9
    clear_obs();
    run(20, 1'b1, 1'b1);
    check_eq("t5_rise_edge", 32'(rise_edge), 32'd9);
    check_eq("t5_rise_width", 32'(rise_cnt), 32'd1);
    run(12, 1'b0, 1'b0);

    // 6: reset on the edge that would complete the qualification
    clear_obs();
    run(5, 1'b1, 1'b0);
    check_eq("t6_cnt_before", 32'(dut.cnt_r), 32'd3);
    step(1'b1, 1'b1, 1'b1);
    check_eq("t6_rst_q", 32'(q), 32'd0);
    check_eq("t6_rst_rise", 32'(rise), 32'd0);
    clear_obs();
    run(10, 1'b1, 1'b0);
    check_eq("t6_rise_edge", 32'(rise_edge), 32'd6);
    check_eq("t6_busy_first", 32'(busy_first), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/d_debounce.md
Name: d_debounce

Overview:
Upstream conditioning stage for the single-bit registered path. It takes an asynchronous, bouncy raw input (switch, button or external pin) and synchronises it into the clk domain. It then debounces the signal with a consecutive-sample counter and delivers a clean level `q` to the downstream D flip-flop stage. It also produces single-cycle rise and fall pulses for edge-triggered consumers.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on d_raw; legal range is 2 to 4.
- STABLE_CYCLES, 50000, number of consecutive qualifying samples that must agree before q changes; legal range is 2 to 2**CNT_W-1.
- CNT_W, 16, width of the stability counter.
- RESET_VAL, 1'b0, value loaded into q and every synchroniser flop on reset.

Ports:
- clk, input, 1, rising-edge clock for all state.
- rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
- ce, input, 1, sample enable; the FSM and counter advance only when ce=1.
- d_raw, input, 1, asynchronous raw input.
- q, output, 1, debounced level (registered).
- rise, output, 1, one-cycle pulse when q goes 0->1 (registered).
- fall, output, 1, one-cycle pulse when q goes 1->0 (registered).
- busy, output, 1, high while a candidate transition is being qualified (FSM in a WAIT state).

Behaviour:
- Reset is decided: one clock, clk; reset rst is synchronous and active-high. On any rising edge of clk with rst=1, regardless of ce:
  - all synchroniser flops <= RESET_VAL;
  - q <= RESET_VAL;
  - state <= STABLE_LO if RESET_VAL=0, otherwise STABLE_HI;
  - cnt <= 0; rise <= 0; fall <= 0; busy <= 0.
- Reset overrides everything, including a qualification that would complete on the same edge. Reset in the middle of a WAIT state discards the partial count and emits no pulse.
- Synchroniser: a SYNC_STAGES-deep flop chain, clocked every cycle and not gated by ce. Its last stage, s, is the FSM input.
- FSM: four states, STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. Transitions are evaluated only on edges where ce=1. When ce=0, state, cnt and q hold and rise/fall are 0.
  - STABLE_LO:
    - s=1 -> WAIT_HI, cnt <= 1.
    - otherwise stay.
  - WAIT_HI:
    - s=0 -> STABLE_LO, cnt <= 0, no pulse.
    - s=1 and cnt==STABLE_CYCLES-1 -> STABLE_HI, q <= 1, rise <= 1, cnt <= 0.
    - otherwise cnt <= cnt+1.
  - STABLE_HI / WAIT_LO: mirror of the two states above with polarity inverted; completion sets q <= 0 and fall <= 1.
- rise and fall:
  - Default to 0 on every edge that does not complete a qualification, so each is high for exactly one clk cycle.
  - They are never high together.
  - Each coincides with the first cycle q shows its new value.
- busy = 1 exactly when the state is WAIT_HI or WAIT_LO (registered with the state).
- Latency with ce tied to 1: after a clean d_raw step that occurs before edge e1, q changes at edge e(SYNC_STAGES+STABLE_CYCLES) and holds from then on.
- Glitch rejection: any excursion of s shorter than STABLE_CYCLES qualifying samples produces no change on q, rise or fall.
- Counter: cnt never exceeds STABLE_CYCLES-1 and never wraps.
- Unqualified cycles: samples taken with ce=0 are not counted and do not reset the count. An excursion spanning ce=0 cycles is judged only on its ce=1 samples.

Test Plan:
Common setup: SYNC_STAGES=2, STABLE_CYCLES=4, RESET_VAL=0, ce=1 unless stated.
1. Hold rst=1 for 2 cycles with d_raw=1, then release -> q=0, rise=0, busy=0 during reset; with d_raw held at 1, q rises 6 edges after release, and rise is high for exactly that one cycle.
2. Step d_raw 0->1 before edge 1 and hold -> busy=1 from edge 3 to edge 5; q=1 and rise=1 at edge 6; rise=0 at edge 7; fall never asserts.
3. Pulse d_raw high for 3 cycles, then return to 0 -> q stays 0, rise and fall stay 0, busy returns to 0, and the count is discarded.
4. Starting from q=1, step d_raw 1->0 and hold -> q=0 and fall=1 at the 6th edge; a following 3-cycle high glitch leaves q at 0.
5. Toggle ce 1,0,1,0,... while d_raw is held high -> q rises only after 4 ce=1 samples of s=1; cnt holds across the ce=0 cycles.
6. Assert rst at the edge where cnt==3 in WAIT_HI -> q=0, rise=0, state STABLE_LO; after release, a fresh 6-edge latency applies.
